// File: rtl/cpu_io_port.sv
// ---------------------------------------------------------------------------
// cpu_io_port
// Peripheral on the far side of the CPU in/out port pair. External input
// words are buffered in an RX FIFO whose head is presented to the CPU; a
// cpu_in_signal pulse acknowledges and pops it. CPU output words are captured
// into a TX FIFO on each cpu_out_signal pulse and drained to an external
// valid/ready stream. Sticky flags record dropped writes and empty reads.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cpu_in_signal       CPU read acknowledge (one pop per high cycle)
//   cpu_in_data         RX head word, 0 when RX is empty
//   cpu_in_avail        RX non-empty
//   cpu_out_signal      CPU write strobe (one push per high cycle)
//   cpu_out_data        CPU output word
//   ext_rx_valid/data   external input stream
//   ext_rx_ready        RX can accept a word
//   ext_tx_valid/data   external output stream (data 0 when TX empty)
//   ext_tx_ready        external sink accepts the TX head
//   rx_count, tx_count  FIFO occupancies, 0..DEPTH
//   overflow            sticky: CPU write dropped because TX was full
//   underflow           sticky: CPU read while RX was empty
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// cpu_io_port_fifo
// Register-array FIFO with read/write pointers and an occupancy count.
// push/pop are qualified internally with full/empty so a push into a full
// FIFO or a pop from an empty one never disturbs state.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   push, wdata  write request and word
//   pop          read request (advances the head)
//   rdata        head word, 0 when empty (combinational)
//   full, empty  derived from the registered count
//   count        occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module cpu_io_port_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push_ok;
    logic             pop_ok;

    // Status from the registered count at the start of the cycle.
    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == CNT_W'(0));
    assign count = cnt;

    // A push into a full FIFO is refused even if a pop happens alongside;
    // a pop from an empty FIFO is ignored even if a push happens alongside.
    assign push_ok = push && !full;
    assign pop_ok  = pop  && !empty;

    // Head word, forced to zero when nothing is buffered.
    assign rdata = empty ? '0 : mem[rd_ptr];

    // Storage has no reset; contents are only observable through rd_ptr
    // while the count is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

module cpu_io_port #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cpu_in_signal,
    output logic [WIDTH-1:0]           cpu_in_data,
    output logic                       cpu_in_avail,
    input  logic                       cpu_out_signal,
    input  logic [WIDTH-1:0]           cpu_out_data,
    input  logic                       ext_rx_valid,
    input  logic [WIDTH-1:0]           ext_rx_data,
    output logic                       ext_rx_ready,
    output logic                       ext_tx_valid,
    output logic [WIDTH-1:0]           ext_tx_data,
    input  logic                       ext_tx_ready,
    output logic [$clog2(DEPTH):0]     rx_count,
    output logic [$clog2(DEPTH):0]     tx_count,
    output logic                       overflow,
    output logic                       underflow
);

    logic rx_full;
    logic rx_empty;
    logic tx_full;
    logic tx_empty;
    logic rx_push;
    logic rx_pop;
    logic tx_push;
    logic tx_pop;

    // RX path: external stream in, CPU reads out.
    // ext_rx_ready does not look at a same-cycle CPU pop, so a full RX
    // refuses a word even while it is being drained.
    assign ext_rx_ready = !rx_full;
    assign rx_push      = ext_rx_valid && !rx_full;
    assign rx_pop       = cpu_in_signal && !rx_empty;
    assign cpu_in_avail = !rx_empty;

    cpu_io_port_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .wdata (ext_rx_data),
        .pop   (rx_pop),
        .rdata (cpu_in_data),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // TX path: CPU writes in, external stream out.
    assign tx_push      = cpu_out_signal && !tx_full;
    assign tx_pop       = ext_tx_ready && !tx_empty;
    assign ext_tx_valid = !tx_empty;

    cpu_io_port_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .wdata (cpu_out_data),
        .pop   (tx_pop),
        .rdata (ext_tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    // Sticky error flags; only reset clears them. overflow uses the
    // start-of-cycle full state, so a same-cycle TX pop does not save the word.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (cpu_out_signal && tx_full) begin
                overflow <= 1'b1;
            end
            if (cpu_in_signal && rx_empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_io_port.sv
// ---------------------------------------------------------------------------
// tb_cpu_io_port
// Directed bench for cpu_io_port (DEPTH=8, WIDTH=64): reset state, RX order
// and underflow, TX fill/overflow/drain, RX full with simultaneous pop,
// continuous push/pop across pointer wrap, and reset mid-traffic.
// ---------------------------------------------------------------------------
module tb_cpu_io_port;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             reset;
    logic             cpu_in_signal;
    logic [WIDTH-1:0] cpu_in_data;
    logic             cpu_in_avail;
    logic             cpu_out_signal;
    logic [WIDTH-1:0] cpu_out_data;
    logic             ext_rx_valid;
    logic [WIDTH-1:0] ext_rx_data;
    logic             ext_rx_ready;
    logic             ext_tx_valid;
    logic [WIDTH-1:0] ext_tx_data;
    logic             ext_tx_ready;
    logic [CNT_W-1:0] rx_count;
    logic [CNT_W-1:0] tx_count;
    logic             overflow;
    logic             underflow;

    int compared;
    int mismatched;

    logic [WIDTH-1:0] rx_q [$];
    logic [WIDTH-1:0] tx_q [$];
    logic [WIDTH-1:0] exp_word;

    cpu_io_port #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_in_signal  (cpu_in_signal),
        .cpu_in_data    (cpu_in_data),
        .cpu_in_avail   (cpu_in_avail),
        .cpu_out_signal (cpu_out_signal),
        .cpu_out_data   (cpu_out_data),
        .ext_rx_valid   (ext_rx_valid),
        .ext_rx_data    (ext_rx_data),
        .ext_rx_ready   (ext_rx_ready),
        .ext_tx_valid   (ext_tx_valid),
        .ext_tx_data    (ext_tx_data),
        .ext_tx_ready   (ext_tx_ready),
        .rx_count       (rx_count),
        .tx_count       (tx_count),
        .overflow       (overflow),
        .underflow      (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        compared       = 0;
        mismatched     = 0;
        reset          = 1'b1;
        cpu_in_signal  = 1'b0;
        cpu_out_signal = 1'b0;
        cpu_out_data   = '0;
        ext_rx_valid   = 1'b0;
        ext_rx_data    = '0;
        ext_tx_ready   = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // ---- reset state after 3 idle cycles
        tick(); tick(); tick();
        chk("rst_rx_count",  64'(rx_count), 64'd0);
        chk("rst_tx_count",  64'(tx_count), 64'd0);
        chk("rst_rx_ready",  64'(ext_rx_ready), 64'd1);
        chk("rst_tx_valid",  64'(ext_tx_valid), 64'd0);
        chk("rst_in_avail",  64'(cpu_in_avail), 64'd0);
        chk("rst_in_data",   cpu_in_data, 64'd0);
        chk("rst_tx_data",   ext_tx_data, 64'd0);
        chk("rst_overflow",  64'(overflow), 64'd0);
        chk("rst_underflow", 64'(underflow), 64'd0);

        // ---- RX order, 1-cycle latency, underflow
        ext_rx_valid = 1'b1;
        ext_rx_data  = 64'h11;
        tick();
        chk("rx_latency_data",  cpu_in_data, 64'h11);
        chk("rx_latency_avail", 64'(cpu_in_avail), 64'd1);
        ext_rx_data = 64'h22;
        tick();
        ext_rx_data = 64'h33;
        tick();
        ext_rx_valid = 1'b0;
        chk("rx_count3", 64'(rx_count), 64'd3);
        for (int i = 1; i <= 3; i++) begin
            cpu_in_signal = 1'b1;
            chk("rx_head_at_pulse", cpu_in_data, 64'(i * 'h11));
            tick();
            cpu_in_signal = 1'b0;
            tick();
        end
        chk("rx_drained_avail", 64'(cpu_in_avail), 64'd0);
        chk("rx_drained_data",  cpu_in_data, 64'd0);
        chk("rx_no_underflow",  64'(underflow), 64'd0);
        cpu_in_signal = 1'b1;
        tick();
        cpu_in_signal = 1'b0;
        chk("underflow_set",      64'(underflow), 64'd1);
        chk("underflow_rx_count", 64'(rx_count), 64'd0);

        // ---- TX fill to full, overflow on the 9th write, drain 1..8
        ext_tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            cpu_out_signal = 1'b1;
            cpu_out_data   = 64'(i);
            tick();
            if (i == 8) chk("tx_full_no_overflow", 64'(overflow), 64'd0);
        end
        cpu_out_signal = 1'b0;
        chk("tx_count_full", 64'(tx_count), 64'd8);
        chk("overflow_set",  64'(overflow), 64'd1);
        chk("tx_valid_full", 64'(ext_tx_valid), 64'd1);
        ext_tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("tx_stream", ext_tx_data, 64'(i));
            tick();
        end
        ext_tx_ready = 1'b0;
        chk("tx_count_empty", 64'(tx_count), 64'd0);
        chk("tx_valid_empty", 64'(ext_tx_valid), 64'd0);
        chk("tx_data_empty",  ext_tx_data, 64'd0);

        // ---- RX full with simultaneous push attempt and pop
        ext_rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ext_rx_data = 64'('hA0 + i);
            tick();
        end
        chk("rx_count_full", 64'(rx_count), 64'd8);
        ext_rx_data   = 64'hB0;
        cpu_in_signal = 1'b1;
        chk("rx_ready_full", 64'(ext_rx_ready), 64'd0);
        chk("rx_head_full",  cpu_in_data, 64'hA0);
        tick();
        cpu_in_signal = 1'b0;
        chk("rx_count_after_pop", 64'(rx_count), 64'd7);
        chk("rx_ready_reopen",    64'(ext_rx_ready), 64'd1);
        tick();
        ext_rx_valid = 1'b0;
        chk("rx_count_refill", 64'(rx_count), 64'd8);
        cpu_in_signal = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            exp_word = (i == 8) ? 64'hB0 : 64'('hA0 + i);
            chk("rx_full_order", cpu_in_data, exp_word);
            tick();
        end
        cpu_in_signal = 1'b0;
        chk("rx_full_drained", 64'(rx_count), 64'd0);

        // ---- continuous traffic: preload 3 words each, then 20 cycles of
        //      simultaneous push and pop on both FIFOs
        ext_rx_valid   = 1'b1;
        cpu_out_signal = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ext_rx_data  = 64'h1000 + 64'(i);
            cpu_out_data = 64'h2000 + 64'(i);
            rx_q.push_back(ext_rx_data);
            tx_q.push_back(cpu_out_data);
            tick();
        end
        cpu_in_signal = 1'b1;
        ext_tx_ready  = 1'b1;
        for (int i = 3; i < 23; i++) begin
            ext_rx_data  = 64'h1000 + 64'(i);
            cpu_out_data = 64'h2000 + 64'(i);
            exp_word = rx_q.pop_front();
            chk("stream_rx_order", cpu_in_data, exp_word);
            exp_word = tx_q.pop_front();
            chk("stream_tx_order", ext_tx_data, exp_word);
            rx_q.push_back(ext_rx_data);
            tx_q.push_back(cpu_out_data);
            tick();
            chk("stream_rx_count", 64'(rx_count), 64'd3);
            chk("stream_tx_count", 64'(tx_count), 64'd3);
        end
        cpu_in_signal  = 1'b0;
        ext_tx_ready   = 1'b0;
        cpu_out_signal = 1'b0;
        chk("stream_rx_next", cpu_in_data, rx_q[0]);
        chk("stream_tx_next", ext_tx_data, tx_q[0]);

        // ---- reset mid-traffic with rx_count=5, tx_count=3
        ext_rx_data = 64'h3000;
        tick();
        ext_rx_data = 64'h3001;
        tick();
        ext_rx_valid = 1'b0;
        chk("pre_rst_rx_count", 64'(rx_count), 64'd5);
        chk("pre_rst_tx_count", 64'(tx_count), 64'd3);
        reset          = 1'b1;
        cpu_out_signal = 1'b1;
        cpu_out_data   = 64'hDEAD;
        ext_rx_valid   = 1'b1;
        tick();
        reset          = 1'b0;
        cpu_out_signal = 1'b0;
        ext_rx_valid   = 1'b0;
        chk("mid_rst_rx_count",  64'(rx_count), 64'd0);
        chk("mid_rst_tx_count",  64'(tx_count), 64'd0);
        chk("mid_rst_tx_valid",  64'(ext_tx_valid), 64'd0);
        chk("mid_rst_in_data",   cpu_in_data, 64'd0);
        chk("mid_rst_tx_data",   ext_tx_data, 64'd0);
        chk("mid_rst_rx_ready",  64'(ext_rx_ready), 64'd1);
        chk("mid_rst_overflow",  64'(overflow), 64'd0);
        chk("mid_rst_underflow", 64'(underflow), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
